multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Main control FSM for the multicycle ARM datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback over several cycles, driving mux selects and write strobes.
- Consumes the condition-check result to squash instructions whose condition fails.
- Stalls on a memory ready handshake; sits beside the flag/condition logic and the ALU decoder.

Parameters:
- CNT_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- Op  in  2  instruction bits [27:26].
- Funct  in  6  instruction bits [25:20]; Funct[5] = immediate, Funct[0] = L (load).
- CondEx  in  1  condition-check result for the instruction held in the IR.
- MemReady  in  1  memory completes the current access this cycle.
- IRWrite  out  1  load instruction register.
- NextPC  out  1  PC write enable for PC+4.
- AdrSrc  out  1  memory address select; 0 = PC, 1 = ALU result.
- ALUSrcA  out  2  ALU A select.
- ALUSrcB  out  2  ALU B select.
- ResultSrc  out  2  result bus select.
- ALUOp  out  1  1 = ALU decoder uses Funct; 0 = forced ADD.
- RegW  out  1  register file write request (gated by CondEx downstream).
- MemW  out  1  memory write request.
- Branch  out  1  branch PC write request.
- Illegal  out  1  one-cycle pulse on undefined Op.
- State  out  4  current state encoding, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9. Encodings 10-15 are unused and return to FETCH on the next clock.
- Reset (reset=0, asynchronous): State=FETCH and all registered state cleared. While reset is held, every strobe (IRWrite, NextPC, RegW, MemW, Branch, Illegal) is 0. Reset mid-instruction abandons the instruction with no write strobe issued.
- Outputs not listed for a state are 0.
- FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, ALUOp=0.
  - IRWrite=NextPC=MemReady (Mealy), so they pulse only in the exit cycle.
  - Hold in FETCH while MemReady=0.
- DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. Next state:
  - CondEx=0 -> FETCH (squash; no strobes).
  - Else Op=01 -> MEMADR.
  - Else Op=00 & Funct[5]=0 -> EXECR.
  - Else Op=00 & Funct[5]=1 -> EXECI.
  - Else Op=10 -> BRANCH.
  - Else Op=11 -> FETCH with Illegal=1 for this cycle.
- MEMADR: ALUSrcA=00, ALUSrcB=01. Funct[0]=1 -> MEMRD, else -> MEMWR.
- MEMRD: AdrSrc=1, ResultSrc=00. Hold while MemReady=0, then -> MEMWB.
- MEMWB: ResultSrc=01, RegW=1 -> FETCH.
- MEMWR: AdrSrc=1, MemW=1 on every held cycle. Hold while MemReady=0; -> FETCH in the cycle MemReady=1.
- EXECR: ALUSrcA=00, ALUSrcB=00, ALUOp=1 -> ALUWB.
- EXECI: ALUSrcA=00, ALUSrcB=01, ALUOp=1 -> ALUWB.
- ALUWB: ResultSrc=00, RegW=1 -> FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH.
- Latency with zero-wait memory: data-processing 4 cycles; LDR 5; STR 4; B 3; squashed 2.
- Op, Funct and CondEx are sampled only in DECODE and MEMADR. Changes to these inputs in other states have no effect.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined: adds output InstrRetired [CNT_W-1:0], reset to 0.
  - Increments by 1 on the exit cycle of MEMWB, ALUWB, BRANCH, and of MEMWR when MemReady=1.
  - Squashed and illegal instructions are not counted.
  - Wraps from all-ones to 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset: reset=0 for 3 cycles mid-EXECR -> State=0, all strobes 0. After release, IRWrite=1 on the first cycle with MemReady=1.
- ADD reg (Op=00, Funct=000000, CondEx=1), MemReady=1 -> states 0,1,6,8,0; RegW=1 only in ALUWB; ALUOp=1 only in EXECR.
- LDR (Op=01, Funct[0]=1), MemReady low 2 cycles in MEMRD -> states 0,1,2,3,3,3,4,0; AdrSrc=1 in MEMRD; RegW=1 in MEMWB only.
- STR (Op=01, Funct[0]=0), MemReady=1 -> MemW=1 for exactly 1 cycle; RegW never 1.
- Condition fail: Op=10, CondEx=0 in DECODE -> FETCH next; Branch=0. Op=11 -> Illegal pulse of exactly 1 cycle.
- MULTICYCLE_CTRL_PERF_EN with CNT_W=4: 17 retired ADDs plus 1 squashed -> InstrRetired=1 (wrapped).

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle ARM control FSM: fetch/decode/execute/memory/writeback sequencing, mux selects, write strobes.
// Latency 2-5 cycles per instruction at zero-wait memory; FETCH, MEMRD and MEMWR hold until MemReady.
// Optional retired-instruction counter under MULTICYCLE_CTRL_PERF_EN.
module multicycle_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       CondEx,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       Illegal,
  output logic [3:0] State
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] InstrRetired
`endif
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  typedef struct packed {
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
  } ctrl_t;

  state_t state_q, state_d;
  ctrl_t  ctrl_q;
  logic   illegal_d;
  logic   unused_funct;

  assign unused_funct = ^Funct[4:1];

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH, S_DECODE: begin
        c.alu_src_a  = 2'b01;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
      end
      S_MEMADR: c.alu_src_b = 2'b01;
      S_MEMRD:  c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_w      = 1'b1;
      end
      S_MEMWR: begin
        c.adr_src = 1'b1;
        c.mem_w   = 1'b1;
      end
      S_EXECR:  c.alu_op = 1'b1;
      S_EXECI: begin
        c.alu_src_b = 2'b01;
        c.alu_op    = 1'b1;
      end
      S_ALUWB:  c.reg_w = 1'b1;
      S_BRANCH: begin
        c.alu_src_b  = 2'b01;
        c.result_src = 2'b10;
        c.branch     = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  if (MemReady) state_d = S_DECODE;
      S_DECODE: begin
        if (!CondEx) begin
          state_d = S_FETCH;
        end else begin
          case (Op)
            2'b01:   state_d = S_MEMADR;
            2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
            2'b10:   state_d = S_BRANCH;
            default: begin
              state_d   = S_FETCH;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (MemReady) state_d = S_MEMWB;
      S_MEMWR:  if (MemReady) state_d = S_FETCH;
      S_EXECR, S_EXECI: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                  ((state_q == S_MEMWR) && MemReady);
  assign InstrRetired = retired_q;
`endif

  // Moore outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      ctrl_q    <= decode_ctrl(S_FETCH);
`ifdef MULTICYCLE_CTRL_PERF_EN
      retired_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d);
`ifdef MULTICYCLE_CTRL_PERF_EN
      if (retire) retired_q <= retired_q + 1'b1;
`endif
    end
  end

  // Mealy strobes are gated by reset so nothing fires while it is held.
  assign IRWrite   = reset && (state_q == S_FETCH) && MemReady;
  assign NextPC    = IRWrite;
  assign Illegal   = reset && illegal_d;
  assign AdrSrc    = ctrl_q.adr_src;
  assign ALUSrcA   = ctrl_q.alu_src_a;
  assign ALUSrcB   = ctrl_q.alu_src_b;
  assign ResultSrc = ctrl_q.result_src;
  assign ALUOp     = ctrl_q.alu_op;
  assign RegW      = ctrl_q.reg_w;
  assign MemW      = ctrl_q.mem_w;
  assign Branch    = ctrl_q.branch;
  assign State     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboarded directed bench for multicycle_ctrl_fsm; expected per-cycle output vectors queued by stimulus.
module tb_multicycle_ctrl_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic       CondEx;
  logic       MemReady;
  logic       IRWrite, NextPC, AdrSrc, ALUOp, RegW, MemW, Branch, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0] State;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [3:0] InstrRetired;
`endif

  int total = 0;
  int bad   = 0;

  string       nmq[$];
  logic [17:0] vq[$];

  multicycle_ctrl_fsm #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .CondEx(CondEx), .MemReady(MemReady),
    .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUOp(ALUOp), .RegW(RegW), .MemW(MemW), .Branch(Branch),
    .Illegal(Illegal), .State(State)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .InstrRetired(InstrRetired)
`endif
  );

  always #5 clk = ~clk;

  // Vector layout: {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch, Illegal}
  function automatic logic [17:0] exp_vec(input logic [3:0] st, input logic ir, input logic ill);
    logic       adr, aluop, regw, memw, br;
    logic [1:0] a, b, r;
    adr = 0; aluop = 0; regw = 0; memw = 0; br = 0; a = 2'b00; b = 2'b00; r = 2'b00;
    case (st)
      4'd0, 4'd1: begin a = 2'b01; b = 2'b10; r = 2'b10; end
      4'd2: b = 2'b01;
      4'd3: adr = 1;
      4'd4: begin r = 2'b01; regw = 1; end
      4'd5: begin adr = 1; memw = 1; end
      4'd6: aluop = 1;
      4'd7: begin b = 2'b01; aluop = 1; end
      4'd8: regw = 1;
      4'd9: begin b = 2'b01; r = 2'b10; br = 1; end
      default: ;
    endcase
    return {st, ir, ir, adr, a, b, r, aluop, regw, memw, br, ill};
  endfunction

  // One cycle: drive inputs just after the edge, queue what the outputs must be this cycle.
  task automatic step(input string nm, input logic rst, input logic [1:0] op, input logic [5:0] fn,
                      input logic ce, input logic mr, input logic [3:0] st, input logic ir, input logic ill);
    reset = rst; Op = op; Funct = fn; CondEx = ce; MemReady = mr;
    nmq.push_back(nm);
    vq.push_back(exp_vec(st, ir, ill));
    @(posedge clk);
    #1;
  endtask

  task automatic run_alu(input logic imm);
    step("alu_fetch",  1, 2'b00, 6'h00,            0, 1, 4'd0, 1, 0);
    step("alu_decode", 1, 2'b00, {imm, 5'b00000},  1, 0, 4'd1, 0, 0);
    step("alu_exec",   1, 2'b11, 6'h3f,            0, 0, imm ? 4'd7 : 4'd6, 0, 0);
    step("alu_wb",     1, 2'b10, 6'h00,            0, 0, 4'd8, 0, 0);
  endtask

  always @(negedge clk) begin
    string       nm;
    logic [17:0] ev, av;
    if (vq.size() > 0) begin
      nm = nmq.pop_front();
      ev = vq.pop_front();
      av = {State, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, RegW, MemW, Branch, Illegal};
      total++;
      if (av !== ev) begin
        bad++;
        $display("FAIL %s: got %b required %b", nm, av, ev);
      end
    end
  end

  initial begin
    reset = 0; Op = 0; Funct = 0; CondEx = 0; MemReady = 1;
    @(posedge clk);
    #1;
    step("reset_hold0", 0, 2'b00, 6'h00, 1, 1, 4'd0, 0, 0);
    step("reset_hold1", 0, 2'b00, 6'h00, 1, 1, 4'd0, 0, 0);
    step("fetch_wait",  1, 2'b00, 6'h00, 1, 0, 4'd0, 0, 0);

    run_alu(1'b0);
    run_alu(1'b1);

    step("ldr_fetch",  1, 2'b00, 6'h00, 0, 1, 4'd0, 1, 0);
    step("ldr_decode", 1, 2'b01, 6'h01, 1, 0, 4'd1, 0, 0);
    step("ldr_memadr", 1, 2'b00, 6'h01, 0, 1, 4'd2, 0, 0);
    step("ldr_memrd0", 1, 2'b00, 6'h00, 0, 0, 4'd3, 0, 0);
    step("ldr_memrd1", 1, 2'b00, 6'h00, 0, 0, 4'd3, 0, 0);
    step("ldr_memrd2", 1, 2'b00, 6'h00, 0, 1, 4'd3, 0, 0);
    step("ldr_memwb",  1, 2'b00, 6'h00, 0, 0, 4'd4, 0, 0);

    step("str_fetch",  1, 2'b00, 6'h00, 0, 1, 4'd0, 1, 0);
    step("str_decode", 1, 2'b01, 6'h00, 1, 0, 4'd1, 0, 0);
    step("str_memadr", 1, 2'b00, 6'h00, 0, 0, 4'd2, 0, 0);
    step("str_memwr",  1, 2'b00, 6'h00, 0, 1, 4'd5, 0, 0);

    step("strw_fetch",  1, 2'b00, 6'h00, 0, 1, 4'd0, 1, 0);
    step("strw_decode", 1, 2'b01, 6'h00, 1, 0, 4'd1, 0, 0);
    step("strw_memadr", 1, 2'b00, 6'h00, 0, 0, 4'd2, 0, 0);
    step("strw_wait",   1, 2'b00, 6'h00, 0, 0, 4'd5, 0, 0);
    step("strw_memwr",  1, 2'b00, 6'h00, 0, 1, 4'd5, 0, 0);

    step("b_fetch",  1, 2'b00, 6'h00, 0, 1, 4'd0, 1, 0);
    step("b_decode", 1, 2'b10, 6'h00, 1, 0, 4'd1, 0, 0);
    step("b_branch", 1, 2'b00, 6'h00, 0, 0, 4'd9, 0, 0);

    step("sq_fetch",  1, 2'b00, 6'h00, 0, 1, 4'd0, 1, 0);
    step("sq_decode", 1, 2'b10, 6'h00, 0, 0, 4'd1, 0, 0);
    step("ill_fetch",  1, 2'b00, 6'h00, 0, 1, 4'd0, 1, 0);
    step("ill_decode", 1, 2'b11, 6'h00, 1, 0, 4'd1, 0, 1);
    step("ill_after",  1, 2'b11, 6'h00, 1, 0, 4'd0, 0, 0);

    step("rx_fetch",  1, 2'b00, 6'h00, 0, 1, 4'd0, 1, 0);
    step("rx_decode", 1, 2'b00, 6'h00, 1, 0, 4'd1, 0, 0);
    step("rx_reset0", 0, 2'b00, 6'h00, 1, 1, 4'd0, 0, 0);
    step("rx_reset1", 0, 2'b00, 6'h00, 1, 1, 4'd0, 0, 0);
    step("rx_reset2", 0, 2'b00, 6'h00, 1, 1, 4'd0, 0, 0);
    step("rx_wait",   1, 2'b00, 6'h00, 1, 0, 4'd0, 0, 0);
    step("rx_fetch2", 1, 2'b00, 6'h00, 1, 1, 4'd0, 1, 0);
    step("rx_decode2",1, 2'b10, 6'h00, 1, 0, 4'd1, 0, 0);
    step("rx_branch", 1, 2'b00, 6'h00, 0, 0, 4'd9, 0, 0);

    step("perf_reset", 0, 2'b00, 6'h00, 0, 0, 4'd0, 0, 0);
    for (int i = 0; i < 17; i++) run_alu(1'b0);
    step("perf_sq_fetch",  1, 2'b00, 6'h00, 0, 1, 4'd0, 1, 0);
    step("perf_sq_decode", 1, 2'b00, 6'h00, 0, 0, 4'd1, 0, 0);
    step("perf_idle",      1, 2'b00, 6'h00, 0, 0, 4'd0, 0, 0);
`ifdef MULTICYCLE_CTRL_PERF_EN
    total++;
    if (InstrRetired !== 4'd1) begin
      bad++;
      $display("FAIL perf_count: got %0d required 1", InstrRetired);
    end
`endif

    for (int i = 0; i < 10 && vq.size() > 0; i++) @(posedge clk);
    total++;
    if (vq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending required 0", vq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
